echo_indication_output: RTL and testbench
=========================================

Name: echo_indication_output

Overview:
- Transmit end of the echo pipe protocol. Accepts indication method calls `heard(meth,v)` and `heard2(a,b)` and encodes each into a 96-bit pipe message `{arg1, arg0, tag}`.
- Buffers encoded messages in a small FIFO and presents them downstream on the `pipe$enq` ENA/RDY interface.
- Mirror of the request-side decoder: what that decoder unpacks, this block packs.

Parameters:
- DEPTH, 4: FIFO entries; legal values are powers of two ≥ 2.
- HEARD_TAG, 32'd0: tag word written for `heard` messages.
- HEARD2_TAG, 32'd1: tag word written for `heard2` messages.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  asynchronous active-low reset.
- indication$heard__ENA  in  1  heard call; asserted only when its RDY is high.
- indication$heard$meth  in  32  heard argument 0.
- indication$heard$v  in  32  heard argument 1.
- indication$heard__RDY  out  1  heard may be called this cycle.
- indication$heard2__ENA  in  1  heard2 call; asserted only when its RDY is high.
- indication$heard2$a  in  16  heard2 argument 0.
- indication$heard2$b  in  16  heard2 argument 1.
- indication$heard2__RDY  out  1  heard2 may be called this cycle.
- pipe$enq__ENA  out  1  message transferred this cycle.
- pipe$enq$v  out  96  message word.
- pipe$enq__RDY  in  1  downstream can accept.

Behaviour:
- Interface: one clock CLK; reset nRST asynchronous, active-low.
- Encoding for `heard`:
  - [31:0] = HEARD_TAG
  - [63:32] = meth
  - [95:64] = v
- Encoding for `heard2`:
  - [31:0] = HEARD2_TAG
  - [63:32] = {16'd0, a}
  - [95:64] = {16'd0, b}
  - Both arguments are zero-extended, never sign-extended.
- FIFO state:
  - Storage `mem[DEPTH]` of 96 bits.
  - Read pointer `rptr` and write pointer `wptr`, each log2(DEPTH) bits; both wrap modulo DEPTH.
  - Occupancy `count` of log2(DEPTH)+1 bits, range 0..DEPTH.
- Method readiness:
  - Both `__RDY = nRST & (DEPTH - count >= 2)`. This guarantees room when both methods fire in the same cycle.
  - RDY depends only on registered state, never on any ENA.
- Single enqueue: in a cycle where exactly one method ENA is high, its encoded message is written at `wptr` and `wptr` advances by 1.
- Simultaneous calls: when both ENAs are high in the same cycle:
  - heard is written at `wptr` and heard2 at `wptr+1`.
  - `wptr` advances by 2.
  - heard is always ordered first.
- Dequeue:
  - `pipe$enq__ENA = (count != 0) & pipe$enq__RDY`, combinational from RDY.
  - `pipe$enq$v = mem[rptr]` (registered storage, no combinational path from inputs).
  - On a transfer, `rptr` advances by 1.
- Count update: same-cycle enqueue(s) and dequeue give `count_next = count + writes - (deq ? 1 : 0)`.
  - A dequeue from count==1 together with an enqueue is legal.
  - The new entry is not visible on `pipe$enq$v` until the next cycle.
- Latency: a call accepted at edge N is offered on `pipe$enq` no earlier than the cycle after edge N.
- Full: count ≥ DEPTH-1 drops both method RDYs.
  - Calls with RDY low are illegal; behaviour on such calls is unspecified and is not to be relied on.
- Empty: `pipe$enq__ENA` is 0 regardless of `pipe$enq__RDY`; `pipe$enq$v` holds the last head value.
- Reset:
  - nRST low asynchronously clears `rptr`, `wptr`, `count` and all `mem` to 0.
  - While nRST is low: `pipe$enq__ENA=0`, `pipe$enq$v=96'd0`, both method RDYs = 0.
  - Reset mid-operation discards all queued messages.
  - After release, both RDYs return to 1 in the first cycle.
- Ordering: messages leave in exact acceptance order; no reordering or drop.

Optional Feature:
- Macro: `ECHO_IND_TRACE_EN`.
- When defined: on each accepted call, print `$display("echo_indication_output::heard %h %h", meth, v)` or the heard2 equivalent with a, b.
  - Then, on each pipe transfer, print `$display("echo_indication_output::enq %h", pipe$enq$v)`.
- When undefined: no `$display` statements compiled; RTL function identical.

Test Plan:
- Reset then single heard(meth=32'h11, v=32'h22) with pipe RDY=1 -> next cycle `pipe$enq__ENA=1`, `pipe$enq$v=96'h00000022_00000011_00000000`; one transfer only.
- heard2(a=16'hABCD, b=16'hFFFF) -> `pipe$enq$v=96'h0000FFFF_0000ABCD_00000001`, with the upper halves of both argument words equal to 0.
- Same-cycle heard(1,2) and heard2(3,4), pipe RDY=1 -> heard message out first, heard2 message the following cycle; count returns to 0.
- Pipe RDY held 0, DEPTH=4: issue heard calls until RDY drops -> exactly 3 accepted, RDYs=0 at count=3; raise pipe RDY -> 3 messages out in order, RDYs return to 1 at count=2.
- Wrap-around: 10 back-to-back heard calls (v=0..9) with pipe RDY toggling 1,0,1,0 -> output v sequence 0..9 in order, no loss or duplicate.
- Assert nRST mid-stream with 2 entries queued -> outputs go 0 immediately (asynchronous); after release `pipe$enq__ENA` stays 0 until a new call is made.

Source files
------------

// File: rtl/echo_indication_output.sv
// Transmit end of the echo pipe: packs heard/heard2 indication calls into 96-bit
// {arg1, arg0, tag} messages, queues them, and offers them on pipe_enq.
// Optional call/transfer tracing is compiled in when ECHO_IND_TRACE_EN is defined.
module echo_indication_output #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] HEARD_TAG  = 32'd0,
   parameter logic [31:0] HEARD2_TAG = 32'd1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        indication_heard__ENA,
   input  logic [31:0] indication_heard_meth,
   input  logic [31:0] indication_heard_v,
   output logic        indication_heard__RDY,
   input  logic        indication_heard2__ENA,
   input  logic [15:0] indication_heard2_a,
   input  logic [15:0] indication_heard2_b,
   output logic        indication_heard2__RDY,
   output logic        pipe_enq__ENA,
   output logic [95:0] pipe_enq_v,
   input  logic        pipe_enq__RDY
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

   logic [95:0]   mem_q [DEPTH];
   logic [95:0]   mem_d [DEPTH];
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   count_q, count_d;

   logic          rdy;
   logic          heard_we, heard2_we, deq;
   logic [1:0]    wr_cnt;
   logic [95:0]   heard_msg, heard2_msg;

   // Two free slots are required so that both methods may fire together.
   assign rdy = nRST & ((DepthW - count_q) >= (AW+1)'(2));

   assign indication_heard__RDY  = rdy;
   assign indication_heard2__RDY = rdy;

   assign heard_we  = indication_heard__ENA & rdy;
   assign heard2_we = indication_heard2__ENA & rdy;
   assign wr_cnt    = {1'b0, heard_we} + {1'b0, heard2_we};

   assign heard_msg  = {indication_heard_v, indication_heard_meth, HEARD_TAG};
   assign heard2_msg = {16'd0, indication_heard2_b, 16'd0, indication_heard2_a, HEARD2_TAG};

   assign deq           = (count_q != '0) & pipe_enq__RDY;
   assign pipe_enq__ENA = deq;
   assign pipe_enq_v    = mem_q[rptr_q];

   always_comb begin
      mem_d = mem_q;
      if (heard_we) begin
         mem_d[wptr_q] = heard_msg;
      end
      // heard is always ordered ahead of heard2 in the same cycle.
      if (heard2_we) begin
         mem_d[heard_we ? wptr_q + AW'(1) : wptr_q] = heard2_msg;
      end
      wptr_d  = wptr_q + AW'(wr_cnt);
      rptr_d  = rptr_q + AW'(deq);
      count_d = count_q + (AW+1)'(wr_cnt) - (AW+1)'(deq);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

`ifdef ECHO_IND_TRACE_EN
   always_ff @(posedge CLK) begin
      if (nRST) begin
         if (heard_we) begin
            $display("echo_indication_output::heard %h %h",
                     indication_heard_meth, indication_heard_v);
         end
         if (heard2_we) begin
            $display("echo_indication_output::heard2 %h %h",
                     indication_heard2_a, indication_heard2_b);
         end
         if (deq) begin
            $display("echo_indication_output::enq %h", pipe_enq_v);
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_echo_indication_output.sv
// Bench for echo_indication_output: directed table, hand-written corner sequences and
// randomized traffic checked against a queue-based message model.
module tb_echo_indication_output;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        h_ena = 1'b0;
   logic [31:0] h_meth = '0;
   logic [31:0] h_v = '0;
   logic        h2_ena = 1'b0;
   logic [15:0] h2_a = '0;
   logic [15:0] h2_b = '0;
   logic        prdy = 1'b0;
   logic        h_rdy, h2_rdy, e_ena;
   logic [95:0] e_v;

   int vec = 0;
   int miss = 0;
   logic [95:0] mq[$];

   always #5 clk = ~clk;

   echo_indication_output #(.DEPTH(DEPTH)) dut (
      .CLK                    (clk),
      .nRST                   (nrst),
      .indication_heard__ENA  (h_ena),
      .indication_heard_meth  (h_meth),
      .indication_heard_v     (h_v),
      .indication_heard__RDY  (h_rdy),
      .indication_heard2__ENA (h2_ena),
      .indication_heard2_a    (h2_a),
      .indication_heard2_b    (h2_b),
      .indication_heard2__RDY (h2_rdy),
      .pipe_enq__ENA          (e_ena),
      .pipe_enq_v             (e_v),
      .pipe_enq__RDY          (prdy)
   );

   typedef struct {
      bit          h;
      logic [31:0] m;
      logic [31:0] v;
      bit          h2;
      logic [15:0] a;
      logic [15:0] b;
      bit          pr;
      bit          rdy;
      bit          ena;
      logic [95:0] ev;
   } vec_t;

   vec_t tbl[10];

   function automatic logic [95:0] enc_heard(logic [31:0] m, logic [31:0] v);
      return (96'(v) << 64) | (96'(m) << 32);
   endfunction

   function automatic logic [95:0] enc_heard2(logic [15:0] a, logic [15:0] b);
      return (96'(b) << 64) | (96'(a) << 32) | 96'd1;
   endfunction

   function automatic bit model_rdy();
      return nrst && ((int'(DEPTH) - mq.size()) >= 2);
   endfunction

   task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(bit h, logic [31:0] m, logic [31:0] v, bit h2, logic [15:0] a,
                        logic [15:0] b, bit pr);
      @(negedge clk);
      h_ena = h; h_meth = m; h_v = v;
      h2_ena = h2; h2_a = a; h2_b = b;
      prdy = pr;
      #1;
   endtask

   task automatic check_model();
      bit exp_ena;
      exp_ena = (mq.size() != 0) && prdy && nrst;
      chk("heard_rdy", 96'(h_rdy), 96'(model_rdy()));
      chk("heard2_rdy", 96'(h2_rdy), 96'(model_rdy()));
      chk("enq_ena", 96'(e_ena), 96'(exp_ena));
      if (!nrst) chk("enq_v_reset", e_v, 96'd0);
      else if (mq.size() != 0) chk("enq_v", e_v, mq[0]);
   endtask

   task automatic commit();
      @(posedge clk);
      if (!nrst) begin
         mq.delete();
      end else begin
         if (mq.size() != 0 && prdy) void'(mq.pop_front());
         if (h_ena) mq.push_back(enc_heard(h_meth, h_v));
         if (h2_ena) mq.push_back(enc_heard2(h2_a, h2_b));
      end
   endtask

   task automatic idle(bit pr);
      drive(1'b0, '0, '0, 1'b0, '0, '0, pr);
      check_model();
      commit();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int accepted;
      logic [31:0] got[$];
      int nxt;

      tbl[0] = '{1'b1, 32'h11, 32'h22, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 96'h0};
      tbl[1] = '{1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1,
                 96'h00000022_00000011_00000000};
      tbl[2] = '{1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 96'h0};
      tbl[3] = '{1'b0, 32'h0, 32'h0, 1'b1, 16'hABCD, 16'hFFFF, 1'b1, 1'b1, 1'b0, 96'h0};
      tbl[4] = '{1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1,
                 96'h0000FFFF_0000ABCD_00000001};
      tbl[5] = '{1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 96'h0};
      tbl[6] = '{1'b1, 32'd1, 32'd2, 1'b1, 16'd3, 16'd4, 1'b1, 1'b1, 1'b0, 96'h0};
      tbl[7] = '{1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1,
                 96'h00000002_00000001_00000000};
      tbl[8] = '{1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1,
                 96'h00000004_00000003_00000001};
      tbl[9] = '{1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 96'h0};

      // Reset state
      prdy = 1'b1;
      #1;
      chk("reset_ena", 96'(e_ena), 96'd0);
      chk("reset_v", e_v, 96'd0);
      chk("reset_rdy", 96'(h_rdy | h2_rdy), 96'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].h, tbl[i].m, tbl[i].v, tbl[i].h2, tbl[i].a, tbl[i].b, tbl[i].pr);
         chk($sformatf("tbl%0d_rdy", i), 96'(h_rdy), 96'(tbl[i].rdy));
         chk($sformatf("tbl%0d_rdy2", i), 96'(h2_rdy), 96'(tbl[i].rdy));
         chk($sformatf("tbl%0d_ena", i), 96'(e_ena), 96'(tbl[i].ena));
         if (tbl[i].ena) chk($sformatf("tbl%0d_v", i), e_v, tbl[i].ev);
         commit();
      end

      // Fill with downstream stalled, then drain
      accepted = 0;
      for (int i = 0; i < 10; i++) begin
         if (model_rdy()) drive(1'b1, 32'h100 + i, 32'h200 + i, 1'b0, '0, '0, 1'b0);
         else drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
         check_model();
         if (h_ena) accepted++;
         commit();
      end
      chk("full_accepted", 96'(accepted), 96'd3);
      idle(1'b1);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      chk("rdy_at_count2", 96'(h_rdy), 96'd1);
      check_model();
      commit();
      repeat (3) idle(1'b1);

      // Wrap-around with downstream toggling
      nxt = 0;
      for (int cyc = 0; cyc < 100 && got.size() < 10; cyc++) begin
         if (nxt < 10 && model_rdy()) begin
            drive(1'b1, 32'h0, 32'(nxt), 1'b0, '0, '0, (cyc % 2) == 0);
            nxt++;
         end else begin
            drive(1'b0, '0, '0, 1'b0, '0, '0, (cyc % 2) == 0);
         end
         check_model();
         if (e_ena) got.push_back(e_v[95:64]);
         commit();
      end
      chk("wrap_count", 96'(got.size()), 96'd10);
      for (int i = 0; i < got.size(); i++) chk($sformatf("wrap_v%0d", i), 96'(got[i]), 96'(i));

      // Asynchronous reset with two entries queued
      repeat (3) idle(1'b1);
      drive(1'b1, 32'hA, 32'hB, 1'b0, '0, '0, 1'b0);
      commit();
      drive(1'b1, 32'hC, 32'hD, 1'b0, '0, '0, 1'b0);
      commit();
      #2;
      nrst = 1'b0;
      prdy = 1'b1;
      h_ena = 1'b0;
      #1;
      chk("async_rst_ena", 96'(e_ena), 96'd0);
      chk("async_rst_v", e_v, 96'd0);
      chk("async_rst_rdy", 96'(h_rdy | h2_rdy), 96'd0);
      mq.delete();
      idle(1'b1);
      @(negedge clk);
      nrst = 1'b1;
      #1;
      chk("post_rst_rdy", 96'(h_rdy & h2_rdy), 96'd1);
      chk("post_rst_ena", 96'(e_ena), 96'd0);
      repeat (3) idle(1'b1);
      drive(1'b0, '0, '0, 1'b1, 16'h8001, 16'h7FFE, 1'b1);
      check_model();
      commit();
      idle(1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit h, h2;
         h  = model_rdy() && ($urandom_range(0, 1) == 1);
         h2 = model_rdy() && ($urandom_range(0, 2) == 0);
         drive(h, $urandom, $urandom, h2, 16'($urandom), 16'($urandom),
               $urandom_range(0, 3) != 0);
         check_model();
         commit();
      end
      for (int i = 0; i < 6; i++) idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
